// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the async FIFO write port among N_REQ wclk-domain requesters.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int D_WIDTH   = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       wclk,
  input  logic                       wrst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  input  logic                       wfull,
  output logic                       winc,
  output logic [D_WIDTH-1:0]         wdata,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy
);
  localparam int OW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t        state;
  logic [OW-1:0] owner, last_owner, nxt;
  logic [BW-1:0] beat;
  logic          xfer, hit;
  // first asserted request searching upward from the slot after the last owner
  always_comb begin
    nxt = last_owner;
    hit = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!hit && req[(int'(last_owner) + k) % N_REQ]) begin
        nxt = OW'((int'(last_owner) + k) % N_REQ);
        hit = 1'b1;
      end
    end
  end
  assign busy  = (state == BURST);
  assign xfer  = busy && req[owner] && !wfull;
  assign winc  = xfer;
  assign ack   = grant & {N_REQ{xfer}};
  assign wdata = busy ? req_data[int'(owner)*D_WIDTH +: D_WIDTH] : '0;
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= OW'(N_REQ - 1);
      beat       <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= BURST;
        owner <= nxt;
        grant <= N_REQ'(1) << nxt;
        beat  <= '0;
      end
    end else if (!req[owner] || (xfer && beat == BW'(MAX_BURST - 1))) begin
      state      <= IDLE;
      grant      <= '0;
      last_owner <= owner;
      beat       <= '0;
    end else if (xfer) begin
      beat <= beat + 1'b1;
    end
  end
endmodule
